// File: rtl/mul_seq.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per cycle.
// Output format matches the repeated-subtraction divider so either unit can feed the same consumer.
module mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [15:0]      result,
    output logic [15:0]      acc_status
);

    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [PW-1:0]    mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q,    acc_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [3:0]       addcnt_q, addcnt_d;
    logic             opzero_q, opzero_d;
    logic [15:0]      result_q, result_d;
    logic [15:0]      status_q, status_d;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        bitcnt_d = bitcnt_q;
        addcnt_d = addcnt_q;
        opzero_d = opzero_q;
        result_d = result_q;
        status_d = status_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d  = ST_RUN;
                    mcand_d  = {{WIDTH{1'b0}}, A};
                    mplier_d = B;
                    acc_d    = '0;
                    bitcnt_d = '0;
                    addcnt_d = '0;
                    opzero_d = (A == '0) || (B == '0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                    if (addcnt_q != 4'hF) begin
                        addcnt_d = addcnt_q + 4'd1;
                    end
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                bitcnt_d = bitcnt_q + 4'd1;
                // Outputs capture this cycle's final accumulation on the edge into DONE.
                if (bitcnt_q == LAST_BIT) begin
                    state_d           = ST_DONE;
                    result_d          = '0;
                    result_d[PW-1:0]  = acc_d;
                    status_d          = '0;
                    status_d[0]       = (acc_d == '0);
                    status_d[1]       = (acc_d[PW-1:WIDTH] != '0);
                    status_d[2]       = opzero_q;
                    status_d[7:4]     = addcnt_d;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            bitcnt_q <= '0;
            addcnt_q <= '0;
            opzero_q <= 1'b0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            bitcnt_q <= bitcnt_d;
            addcnt_q <= addcnt_d;
            opzero_q <= opzero_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    assign BUSY       = (state_q == ST_RUN);
    assign DONE       = (state_q == ST_DONE);
    assign result     = result_q;
    assign acc_status = status_q;

endmodule
